// File: rtl/alu_decoder.sv
// ALU decoder: maps data-processing cmd/S to ALU select, flag-write enables,
// write-back suppression and illegal-op indication, all registered.
module alu_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Funct40,
    input  logic       ALUOp,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       Illegal
);

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ORR = 2'b11;

    logic [3:0] cmd_s;
    logic       s_bit_s;
    logic [1:0] alu_control_s;
    logic [1:0] flag_w_s;
    logic       no_write_s;
    logic       illegal_s;

    assign cmd_s   = Funct40[4:1];
    assign s_bit_s = Funct40[0];

    // Next-cycle decode of the command field; logical ops never touch C,V.
    always_comb begin
        alu_control_s = OP_ADD;
        flag_w_s      = 2'b00;
        no_write_s    = 1'b0;
        illegal_s     = 1'b0;
        if (ALUOp) begin
            case (cmd_s)
                CMD_ADD: begin
                    alu_control_s = OP_ADD;
                    flag_w_s      = s_bit_s ? 2'b11 : 2'b00;
                end
                CMD_SUB: begin
                    alu_control_s = OP_SUB;
                    flag_w_s      = s_bit_s ? 2'b11 : 2'b00;
                end
                CMD_AND: begin
                    alu_control_s = OP_AND;
                    flag_w_s      = s_bit_s ? 2'b10 : 2'b00;
                end
                CMD_ORR: begin
                    alu_control_s = OP_ORR;
                    flag_w_s      = s_bit_s ? 2'b10 : 2'b00;
                end
                CMD_CMP: begin
                    alu_control_s = OP_SUB;
                    flag_w_s      = 2'b11;
                    no_write_s    = 1'b1;
                end
                default: begin
                    // Unsupported op must not modify flags or registers.
                    alu_control_s = OP_ADD;
                    flag_w_s      = 2'b00;
                    no_write_s    = 1'b1;
                    illegal_s     = 1'b1;
                end
            endcase
        end else begin
            alu_control_s = OP_ADD;
            flag_w_s      = 2'b00;
            no_write_s    = 1'b0;
            illegal_s     = 1'b0;
        end
    end

    // Output register; reset wins over decode even with unknown inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUControl <= 2'b00;
            FlagW      <= 2'b00;
            NoWrite    <= 1'b0;
            Illegal    <= 1'b0;
        end else begin
            ALUControl <= alu_control_s;
            FlagW      <= flag_w_s;
            NoWrite    <= no_write_s;
            Illegal    <= illegal_s;
        end
    end

endmodule

// File: tb/tb_alu_decoder.sv
// Directed plus randomized bench for alu_decoder against a rule-level model.
module tb_alu_decoder;

    logic       clk;
    logic       reset;
    logic [4:0] Funct40;
    logic       ALUOp;
    logic [1:0] ALUControl;
    logic [1:0] FlagW;
    logic       NoWrite;
    logic       Illegal;

    int checks;
    int failures;

    alu_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .Funct40    (Funct40),
        .ALUOp      (ALUOp),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .NoWrite    (NoWrite),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {ALUControl, FlagW, NoWrite, Illegal} from the instruction-set rules.
    function automatic logic [5:0] model(input logic r, input logic a, input logic [4:0] f);
        int  cmd;
        bit  s, arith, logical, cmp;
        int  ctrl;
        bit  fw_nz, fw_cv, nw, ill;
        if (r === 1'b1) return 6'b000000;
        if (a == 1'b0) return 6'b000000;
        cmd     = int'(f) / 2;
        s       = f[0];
        arith   = (cmd == 4) || (cmd == 2);
        logical = (cmd == 0) || (cmd == 12);
        cmp     = (cmd == 10);
        ill     = !(arith || logical || cmp);
        if (cmd == 4)       ctrl = 0;
        else if (cmd == 2)  ctrl = 1;
        else if (cmd == 10) ctrl = 1;
        else if (cmd == 0)  ctrl = 2;
        else if (cmd == 12) ctrl = 3;
        else                ctrl = 0;
        fw_nz = cmp || (s && (arith || logical));
        fw_cv = cmp || (s && arith);
        nw    = cmp || ill;
        return {ctrl[1:0], fw_nz, fw_cv, nw, ill};
    endfunction

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {ALUControl, FlagW, NoWrite, Illegal};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive at negedge, check one cycle later just after the rising edge.
    task automatic step(input string tag, input logic r, input logic a, input logic [4:0] f);
        logic [5:0] exp;
        @(negedge clk);
        reset   = r;
        ALUOp   = a;
        Funct40 = f;
        exp     = model(r, a, f);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [5:0] held;
        logic       ra;
        logic [4:0] rf;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ALUOp    = 1'bx;
        Funct40  = 5'bxxxxx;

        @(posedge clk);
        #1;
        check("reset_x_1", 6'b000000);
        @(posedge clk);
        #1;
        check("reset_x_2", 6'b000000);
        step("post_reset", 1'b0, 1'b0, 5'b00000);

        step("add_nos", 1'b0, 1'b1, 5'b01000);
        step("add_s",   1'b0, 1'b1, 5'b01001);
        step("sub_nos", 1'b0, 1'b1, 5'b00100);
        step("sub_s",   1'b0, 1'b1, 5'b00101);
        step("and_nos", 1'b0, 1'b1, 5'b00000);
        step("and_s",   1'b0, 1'b1, 5'b00001);
        step("orr_nos", 1'b0, 1'b1, 5'b11000);
        step("orr_s",   1'b0, 1'b1, 5'b11001);
        step("cmp_nos", 1'b0, 1'b1, 5'b10100);
        step("cmp_s",   1'b0, 1'b1, 5'b10101);
        step("illegal", 1'b0, 1'b1, 5'b11110);
        step("aluop0",  1'b0, 1'b0, 5'b00101);

        // Mid-cycle input change must not reach outputs before the edge.
        step("hold_pre", 1'b0, 1'b1, 5'b10100);
        held = model(1'b0, 1'b1, 5'b10100);
        ALUOp   = 1'b1;
        Funct40 = 5'b11110;
        #2;
        check("hold_mid", held);
        @(posedge clk);
        #1;
        check("hold_next", model(1'b0, 1'b1, 5'b11110));

        step("reset_prio", 1'b1, 1'b1, 5'b00101);

        for (int i = 0; i < 200; i++) begin
            ra = 1'($urandom_range(0, 3) != 0);
            rf = 5'($urandom_range(0, 31));
            step("random", 1'($urandom_range(0, 15) == 0), ra, rf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
